// File: rtl/fpunpack_norm.sv
// IEEE-754 operand unpacker: splits {sign, exponent, fraction} into an unbiased
// exponent and explicit-leading-bit significand, normalising subnormals one bit per cycle.
module fpunpack_norm #(
    parameter int NE = 5,
    parameter int NF = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NE+NF:0]       f,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sign,
    output logic signed [NE+1:0] exp,
    output logic [NF:0]          mant,
    output logic                 zero,
    output logic                 inf,
    output logic                 nan,
    output logic                 snan,
    output logic                 subnorm
);
    localparam int FLEN = 1 + NE + NF;
    localparam int BIAS = (1 << (NE - 1)) - 1;

    localparam logic signed [NE+1:0] C_BIAS    = (NE+2)'(BIAS);
    localparam logic signed [NE+1:0] C_EXP_SUB = (NE+2)'(1 - BIAS);
    localparam logic signed [NE+1:0] C_EXP_SPC = (NE+2)'(BIAS + 1);
    localparam logic signed [NE+1:0] C_ONE     = (NE+2)'(1);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t r_state;

    logic [NE-1:0]         w_efield;
    logic [NF-1:0]         w_fract;
    logic                  w_ezero;
    logic                  w_eones;
    logic                  w_fzero;
    logic                  w_accept;
    logic signed [NE+1:0]  w_ld_exp;
    logic [NF:0]           w_ld_mant;

    assign w_efield = f[FLEN-2:NF];
    assign w_fract  = f[NF-1:0];
    assign w_ezero  = (w_efield == '0);
    assign w_eones  = (w_efield == '1);
    assign w_fzero  = (w_fract == '0);

    // out_ready -> in_ready is the only combinational path through the block
    assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_ld_exp  = $signed({2'b00, w_efield}) - C_BIAS;
        w_ld_mant = {1'b1, w_fract};
        if (w_ezero && w_fzero) begin
            w_ld_exp  = '0;
            w_ld_mant = '0;
        end else if (w_ezero) begin
            w_ld_exp  = C_EXP_SUB;
            w_ld_mant = {1'b0, w_fract};
        end else if (w_eones) begin
            w_ld_exp  = C_EXP_SPC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            sign      <= 1'b0;
            exp       <= '0;
            mant      <= '0;
            zero      <= 1'b0;
            inf       <= 1'b0;
            nan       <= 1'b0;
            snan      <= 1'b0;
            subnorm   <= 1'b0;
        end else begin
            // A load happens from IDLE, or from DONE when the held result is taken
            if (w_accept) begin
                sign      <= f[FLEN-1];
                exp       <= w_ld_exp;
                mant      <= w_ld_mant;
                zero      <= w_ezero && w_fzero;
                subnorm   <= w_ezero && !w_fzero;
                inf       <= w_eones && w_fzero;
                nan       <= w_eones && !w_fzero;
                snan      <= w_eones && !w_fzero && !w_fract[NF-1];
                r_state   <= (w_ezero && !w_fzero) ? NORM : DONE;
                out_valid <= !(w_ezero && !w_fzero);
            end else begin
                case (r_state)
                    NORM: begin
                        mant <= mant << 1;
                        exp  <= exp - C_ONE;
                        if (mant[NF-1]) begin
                            r_state   <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            r_state   <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fpunpack_norm.sv
// Directed-vector and random-stream bench for fpunpack_norm (NE=5, NF=10).
module tb_fpunpack_norm;
    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       f;
    logic              out_valid;
    logic              out_ready;
    logic              d_sign;
    logic signed [6:0] d_exp;
    logic [10:0]       d_mant;
    logic              d_zero, d_inf, d_nan, d_snan, d_sub;

    int n_cmp = 0;
    int n_bad = 0;

    fpunpack_norm #(.NE(5), .NF(10)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .f(f),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign(d_sign), .exp(d_exp), .mant(d_mant),
        .zero(d_zero), .inf(d_inf), .nan(d_nan), .snan(d_snan), .subnorm(d_sub)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]       f;
        logic              s;
        logic signed [6:0] e;
        logic [10:0]       m;
        logic [4:0]        fl;   // {zero, inf, nan, snan, subnorm}
        int                lat;
    } vec_t;

    vec_t tv[13];

    function automatic logic [23:0] got();
        return {d_sign, d_exp, d_mant, d_zero, d_inf, d_nan, d_snan, d_sub};
    endfunction

    // Reference decode; subnormals located by scanning for the top set bit
    function automatic logic [23:0] model(input logic [15:0] x);
        logic [4:0] ef;
        logic [9:0] fr;
        int p;
        int e;
        logic [10:0] m;
        ef = x[14:10];
        fr = x[9:0];
        if (ef == 0 && fr == 0) return {x[15], 7'd0, 11'd0, 5'b10000};
        if (ef == 0) begin
            p = 0;
            for (int i = 0; i < 10; i++) if (fr[i]) p = i;
            e = -14 - (10 - p);
            m = {1'b0, fr} << (10 - p);
            return {x[15], 7'(e), m, 5'b00001};
        end
        if (ef == 31) begin
            if (fr == 0) return {x[15], 7'd16, {1'b1, fr}, 5'b01000};
            return {x[15], 7'd16, {1'b1, fr}, 2'b00, 1'b1, ~fr[9], 1'b0};
        end
        e = int'(ef) - 15;
        return {x[15], 7'(e), {1'b1, fr}, 5'b00000};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; f = '0;
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Accept one operand at the next edge; returns cycles until out_valid (or -1)
    task automatic send_wait(input logic [15:0] x, output int lat);
        @(negedge clk);
        in_valid = 1'b1; f = x;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (out_valid) begin lat = n; break; end
        end
    endtask

    initial begin
        int lat;
        logic [23:0] held;
        logic [23:0] exq[$];
        logic [23:0] e1;
        int n_acc, n_out;

        tv[0]  = '{16'h3C00, 1'b0,  7'sd0,   11'h400, 5'b00000, 1};
        tv[1]  = '{16'h0001, 1'b0, -7'sd24,  11'h400, 5'b00001, 11};
        tv[2]  = '{16'h0200, 1'b0, -7'sd15,  11'h400, 5'b00001, 2};
        tv[3]  = '{16'h7C01, 1'b0,  7'sd16,  11'h401, 5'b00110, 1};
        tv[4]  = '{16'h7E00, 1'b0,  7'sd16,  11'h600, 5'b00100, 1};
        tv[5]  = '{16'hFC00, 1'b1,  7'sd16,  11'h400, 5'b01000, 1};
        tv[6]  = '{16'h8000, 1'b1,  7'sd0,   11'h000, 5'b10000, 1};
        tv[7]  = '{16'h4000, 1'b0,  7'sd1,   11'h400, 5'b00000, 1};
        tv[8]  = '{16'h7BFF, 1'b0,  7'sd15,  11'h7FF, 5'b00000, 1};
        tv[9]  = '{16'h0400, 1'b0, -7'sd14,  11'h400, 5'b00000, 1};
        tv[10] = '{16'h03FF, 1'b0, -7'sd15,  11'h7FE, 5'b00001, 2};
        tv[11] = '{16'h0010, 1'b0, -7'sd20,  11'h400, 5'b00001, 7};
        tv[12] = '{16'hC100, 1'b1,  7'sd1,   11'h500, 5'b00000, 1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; f = '0;
        do_reset();
        @(negedge clk);
        chk("reset_outputs", {7'd0, out_valid, got()}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            send_wait(tv[i].f, lat);
            chk($sformatf("latency_%h", tv[i].f), lat, tv[i].lat);
            chk($sformatf("result_%h", tv[i].f), {8'd0, got()},
                {8'd0, tv[i].s, tv[i].e, tv[i].m, tv[i].fl});
        end

        // Backpressure hold, then simultaneous take and accept
        @(negedge clk); out_ready = 1'b0;
        send_wait(16'h3C00, lat);
        chk("bp_latency", lat, 1);
        held = got();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {7'd0, out_valid, got()}, {7'd0, 1'b1, held});
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1; in_valid = 1'b1; f = 16'h4000;
        #1 chk("bp_in_ready_take", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next", {7'd0, out_valid, got()}, {7'd0, 1'b1, 1'b0, 7'sd1, 11'h400, 5'b00000});

        // Reset during subnormal normalisation discards the operand
        @(negedge clk);
        in_valid = 1'b1; f = 16'h0001;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_norm_outputs", {7'd0, out_valid, got()}, 32'd0);
        chk("rst_norm_in_ready", {31'd0, in_ready}, 32'd1);
        lat = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        chk("rst_norm_no_output", lat, 0);

        // Random stream with random backpressure, scoreboarded in order
        n_acc = 0; n_out = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (c < 500) begin
                in_valid = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0: f = {$urandom_range(0, 1) == 1, 5'd0, 10'($urandom)};
                    1: f = {$urandom_range(0, 1) == 1, 5'd31, 10'($urandom)};
                    default: f = 16'($urandom);
                endcase
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (out_valid && out_ready) begin
                n_out++;
                if (exq.size() == 0) chk("stream_extra_result", {8'd0, got()}, 32'hFFFFFFFF);
                else begin
                    e1 = exq.pop_front();
                    chk("stream_result", {8'd0, got()}, {8'd0, e1});
                end
            end
            if (in_valid && in_ready) begin
                n_acc++;
                exq.push_back(model(f));
            end
        end
        chk("stream_count", n_out, n_acc);
        chk("stream_drained", exq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
